fetch_unit: RTL
===============

Name:
fetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle register/ALU/immediate datapath.
- Owns the PC and runs a request/acknowledge handshake with instruction memory. Accepts variable memory latency.
- Holds the fetched word stable on `instr` for the datapath's execute cycle.
- Advances the PC to PC+4, or to PC+IMM when the control path signals a taken branch; the branch decision comes from EQ.

Parameters:
- WD, 32, data/address width in bits.
- PC_RESET, 32'h0000_0000, PC value loaded on reset. Must be word-aligned.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  WD  fetch address; equals pc while imem_req=1.
- imem_ack  input  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  input  WD  instruction word from memory.
- branch_take  input  1  control decision: take branch (already qualified with EQ).
- IMM  input  WD  sign-extended branch offset from the immediate generator.
- stall  input  1  hold the current instruction for another execute cycle.
- instr  output  WD  instruction presented to the datapath/decoder.
- instr_valid  output  1  instr holds a fetched word in its execute cycle.
- pc  output  WD  address of the current instruction.

Behaviour:
- Clock/reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- While rst=1:
  - state=IDLE, pc=PC_RESET, instr=0, instr_valid=0.
  - imem_req=0, imem_addr=0.
- FSM states: IDLE, FETCH, EXEC.
- IDLE: all outputs at reset values. Unconditional transition to FETCH on the next edge, giving one bubble cycle after reset release.
- FETCH:
  - imem_req=1 and imem_addr=pc, asserted combinationally from state.
  - Request stays asserted and the address stays stable until imem_ack=1.
  - On an edge with imem_ack=1: instr<=imem_rdata, instr_valid<=1, state<=EXEC.
  - Zero-wait memory (ack in the first FETCH cycle) is legal.
- EXEC:
  - imem_req=0. instr and pc are stable; this is the datapath's execute cycle.
  - stall=1: remain in EXEC; instr, pc and instr_valid are unchanged; branch_take is ignored.
  - stall=0: on the edge, pc<=branch_take ? (pc+IMM) : (pc+4); instr_valid<=0; state<=FETCH.
  - instr retains its old value but is qualified invalid.
- Throughput: minimum 2 cycles per instruction (FETCH with immediate ack, then EXEC).
- Arithmetic:
  - All PC sums are WD-bit, modulo 2^WD. pc+4 from 32'hFFFF_FFFC wraps to 0.
  - The branch target has bits [1:0] forced to 0.
  - pc[1:0] is always 0.
- imem_ack outside FETCH is ignored. No state change, no capture.
- imem_rdata is sampled only on an edge with FETCH and imem_ack both true.
- Reset asserted mid-FETCH or mid-EXEC aborts immediately. Any outstanding memory response is discarded, because memory sees imem_req drop.
- branch_take and IMM are sampled only on the EXEC edge with stall=0.

Optional Feature:
- Macro: FETCH_INSTRET_EN.
- When defined:
  - Extra output port `instret`, width WD: count of retired instructions.
  - Reset value 0.
  - Increments by 1 on every EXEC edge with stall=0; wraps from all-ones to 0.
  - Not incremented in stalled cycles.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then release, memory acks in the same cycle it sees a request with rdata=32'h0050_0093:
  - the cycle after release: IDLE, imem_req=0;
  - next cycle: imem_req=1, imem_addr=0;
  - next cycle: instr=32'h0050_0093, instr_valid=1;
  - then the next fetch is at addr 4.
- Memory ack delayed 3 cycles: imem_req stays 1 and imem_addr stays 0 for 3 cycles; instr_valid stays 0 until the ack edge.
- In EXEC at pc=32'h10 with branch_take=1, IMM=32'hFFFF_FFF8: next imem_addr=32'h08. Repeat with branch_take=0: next imem_addr=32'h14.
- stall=1 for 2 EXEC cycles with branch_take toggling: pc, instr and instr_valid are unchanged for both cycles; after stall drops, branch_take=0 gives pc+4 exactly once. With FETCH_INSTRET_EN defined, instret increments by 1 total.
- pc=32'hFFFF_FFFC, EXEC with branch_take=0: the next fetch address is 0.
- Assert rst during FETCH with memory ack pending:
  - instr_valid=0, imem_req=0 and pc=PC_RESET while rst=1;
  - an ack arriving during IDLE does not change instr.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and runs a req/ack handshake with instruction memory.
// Optional macro FETCH_INSTRET_EN adds the retired-instruction counter output `instret`.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | bubble cycle after reset release, outputs at reset values
// FETCH | imem_req=1 with imem_addr=pc, waiting for imem_ack
// EXEC  | instr/pc held stable for the datapath; stall extends the cycle
module fetch_unit #(
    parameter int              WD       = 32,
    parameter logic [WD-1:0]   PC_RESET = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [WD-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [WD-1:0] imem_rdata,
    input  logic          branch_take,
    input  logic [WD-1:0] IMM,
    input  logic          stall,
    output logic [WD-1:0] instr,
    output logic          instr_valid,
    output logic [WD-1:0] pc
`ifdef FETCH_INSTRET_EN
    ,
    output logic [WD-1:0] instret
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

    localparam logic [WD-1:0] ALIGN_MASK = ~WD'(3);
    localparam logic [WD-1:0] PC_INIT    = PC_RESET & ALIGN_MASK;

    state_t        state;
    logic [WD-1:0] br_target;

    // Branch targets are word-aligned regardless of the offset's low bits.
    always_comb begin
        br_target = (pc + IMM) & ALIGN_MASK;
    end

    assign imem_req  = (state == FETCH);
    assign imem_addr = imem_req ? pc : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= PC_INIT;
            instr       <= '0;
            instr_valid <= 1'b0;
`ifdef FETCH_INSTRET_EN
            instret     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        pc          <= branch_take ? br_target : pc + WD'(4);
                        instr_valid <= 1'b0;
                        state       <= FETCH;
`ifdef FETCH_INSTRET_EN
                        instret     <= instret + WD'(1);
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
